// File: rtl/qr_pe_pkg.sv
// qr_pe_pkg: shared mode encodings, FSM state type and iteration limit for the QR processing element
package qr_pe_pkg;
  localparam logic M_VECTORING = 1'b1;
  localparam logic M_ROTATION = 1'b0;
  localparam int NUM_ITER_MAX = 15;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PH1 = 2'd1, S_PH2 = 2'd2, S_DONE = 2'd3} state_t;
endpackage

// File: rtl/qr_pe_param_cordic_iter.sv
// cordic_iter: one registered saturating CORDIC micro-rotation (i_x/i_y by 2^-i_shift); o_dir=1 means d=-1, self-chosen when i_vec
module cordic_iter #(
  parameter int W = 14,
  parameter int SW = 3
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_vec,
  input  logic                i_dir,
  input  logic [SW-1:0]       i_shift,
  input  logic signed [W-1:0] i_x,
  input  logic signed [W-1:0] i_y,
  output logic signed [W-1:0] o_x,
  output logic signed [W-1:0] o_y,
  output logic                o_dir
);
  logic signed [W:0] xe, ye, xs, ys, x_n, y_n;
  logic signed [W-1:0] x_d, y_d, x_q, y_q;
  always_comb begin
    o_dir = i_vec ? ~i_y[W-1] : i_dir;
    xe = (W+1)'(i_x);
    ye = (W+1)'(i_y);
    xs = (W+1)'(i_x >>> i_shift);
    ys = (W+1)'(i_y >>> i_shift);
    x_n = o_dir ? xe + ys : xe - ys;
    y_n = o_dir ? ye - xs : ye + xs;
    x_d = (x_n[W] ^ x_n[W-1]) ? {x_n[W], {(W-1){~x_n[W]}}} : x_n[W-1:0];
    y_d = (y_n[W] ^ y_n[W-1]) ? {y_n[W], {(W-1){~y_n[W]}}} : y_n[W-1:0];
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (i_en) begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end
  assign o_x = x_q;
  assign o_y = y_q;
endmodule

// File: rtl/qr_pe_param.sv
// qr_pe_param: two-phase complex CORDIC QR cell; i_* operands/handshake in, o_* results/handshake out, o_busy while working
module qr_pe_param
  import qr_pe_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int GUARD_W = 2,
  parameter int NUM_ITER = 6
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_mode,
  input  logic signed [DATA_W-1:0] i_real_x,
  input  logic signed [DATA_W-1:0] i_imag_x,
  input  logic signed [DATA_W-1:0] i_real_y,
  input  logic signed [DATA_W-1:0] i_imag_y,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_mode,
  output logic signed [DATA_W-1:0] o_real_x,
  output logic signed [DATA_W-1:0] o_imag_x,
  output logic signed [DATA_W-1:0] o_real_y,
  output logic signed [DATA_W-1:0] o_imag_y,
  output logic                     o_busy
);
  localparam int W = DATA_W + GUARD_W;
  localparam int NI = NUM_ITER > NUM_ITER_MAX ? NUM_ITER_MAX : (NUM_ITER < 2 ? 2 : NUM_ITER);
  localparam int CW = $clog2(NI);
  typedef logic signed [W-1:0] wd_t;
  typedef logic signed [DATA_W-1:0] dw_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mode_q, mode_d, fa_q, fa_d, fb_q, fb_d, valid_q, valid_d, omode_q, omode_d;
  logic [NI-1:0] dir_a_q, dir_a_d, dir_b_q, dir_b_d, dir_c_q, dir_c_d;
  wd_t xr_q, xr_d, xi_q, xi_d, yr_q, yr_d, yi_q, yi_d;
  dw_t rx_q, rx_d, ix_q, ix_d, ry_q, ry_d, iy_q, iy_d;
  wd_t a_xi, a_yi, b_xi, b_yi, a_xo, a_yo, b_xo, b_yo;
  logic a_di, b_di, a_do, b_do, ph1, ph2, first, last, acc, neg_a, neg_b, vec, done_ld;
  function automatic wd_t ext(dw_t v);
    return {{GUARD_W{v[DATA_W-1]}}, v};
  endfunction
  function automatic dw_t sat(wd_t v);
    return (v[W-1:DATA_W-1] == {(GUARD_W+1){v[W-1]}}) ? v[DATA_W-1:0] : {v[W-1], {(DATA_W-1){~v[W-1]}}};
  endfunction
  always_comb begin
    ph1 = state_q == S_PH1;
    ph2 = state_q == S_PH2;
    first = cnt_q == '0;
    last = cnt_q == CW'(NI-1);
    vec = mode_q == M_VECTORING;
    acc = state_q == S_IDLE && i_valid;
    done_ld = state_q == S_DONE && !valid_q;
    // vectoring derives the quadrant flag from the operand; rotation replays the stored one
    neg_a = i_mode == M_VECTORING ? i_real_x[DATA_W-1] : fa_q;
    neg_b = i_mode == M_VECTORING ? i_real_y[DATA_W-1] : fb_q;
    // PH2 first step reloads A with (A.x, B.x) and B with (A.y, B.y)
    a_xi = ph1 && first ? xr_q : a_xo;
    a_yi = first ? (ph1 ? xi_q : b_xo) : a_yo;
    b_xi = first ? (ph1 ? yr_q : a_yo) : b_xo;
    b_yi = ph1 && first ? yi_q : b_yo;
    a_di = ph1 ? dir_a_q[cnt_q] : dir_c_q[cnt_q];
    b_di = ph1 ? dir_b_q[cnt_q] : dir_c_q[cnt_q];
    xr_d = acc ? (neg_a ? -ext(i_real_x) : ext(i_real_x)) : xr_q;
    xi_d = acc ? (neg_a ? -ext(i_imag_x) : ext(i_imag_x)) : xi_q;
    yr_d = acc ? (neg_b ? -ext(i_real_y) : ext(i_real_y)) : yr_q;
    yi_d = acc ? (neg_b ? -ext(i_imag_y) : ext(i_imag_y)) : yi_q;
    fa_d = acc && i_mode == M_VECTORING ? i_real_x[DATA_W-1] : fa_q;
    fb_d = acc && i_mode == M_VECTORING ? i_real_y[DATA_W-1] : fb_q;
    mode_d = acc ? i_mode : mode_q;
    cnt_d = (ph1 || ph2) && !last ? cnt_q + 1'b1 : '0;
    state_d = acc ? S_PH1 : ph1 && last ? S_PH2 : ph2 && last ? S_DONE :
              state_q == S_DONE && valid_q && i_ready ? S_IDLE : state_q;
    dir_a_d = dir_a_q;
    dir_b_d = dir_b_q;
    dir_c_d = dir_c_q;
    if (vec && ph1) dir_a_d[cnt_q] = a_do;
    if (vec && ph1) dir_b_d[cnt_q] = b_do;
    if (vec && ph2) dir_c_d[cnt_q] = a_do;
    valid_d = done_ld ? 1'b1 : valid_q && i_ready ? 1'b0 : valid_q;
    omode_d = done_ld ? mode_q : omode_q;
    rx_d = done_ld ? sat(a_xo) : rx_q;
    ry_d = done_ld ? sat(a_yo) : ry_q;
    ix_d = done_ld ? (mode_q == M_ROTATION ? sat(b_xo) : '0) : ix_q;
    iy_d = done_ld ? (mode_q == M_ROTATION ? sat(b_yo) : '0) : iy_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      mode_q <= 1'b0;
      fa_q <= 1'b0;
      fb_q <= 1'b0;
      valid_q <= 1'b0;
      omode_q <= 1'b0;
      dir_a_q <= '0;
      dir_b_q <= '0;
      dir_c_q <= '0;
      xr_q <= '0;
      xi_q <= '0;
      yr_q <= '0;
      yi_q <= '0;
      rx_q <= '0;
      ix_q <= '0;
      ry_q <= '0;
      iy_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
      fa_q <= fa_d;
      fb_q <= fb_d;
      valid_q <= valid_d;
      omode_q <= omode_d;
      dir_a_q <= dir_a_d;
      dir_b_q <= dir_b_d;
      dir_c_q <= dir_c_d;
      xr_q <= xr_d;
      xi_q <= xi_d;
      yr_q <= yr_d;
      yi_q <= yi_d;
      rx_q <= rx_d;
      ix_q <= ix_d;
      ry_q <= ry_d;
      iy_q <= iy_d;
    end
  end
  cordic_iter #(.W(W), .SW(CW)) u_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(ph1 || ph2), .i_vec(vec), .i_dir(a_di),
    .i_shift(cnt_q), .i_x(a_xi), .i_y(a_yi), .o_x(a_xo), .o_y(a_yo), .o_dir(a_do)
  );
  cordic_iter #(.W(W), .SW(CW)) u_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(ph1 || (ph2 && mode_q == M_ROTATION)), .i_vec(vec), .i_dir(b_di),
    .i_shift(cnt_q), .i_x(b_xi), .i_y(b_yi), .o_x(b_xo), .o_y(b_yo), .o_dir(b_do)
  );
  assign o_ready = state_q == S_IDLE;
  assign o_busy = state_q != S_IDLE;
  assign o_valid = valid_q;
  assign o_mode = omode_q;
  assign o_real_x = rx_q;
  assign o_imag_x = ix_q;
  assign o_real_y = ry_q;
  assign o_imag_y = iy_q;
endmodule

// File: tb/tb_qr_pe_param.sv
// tb_qr_pe_param: scoreboard bench for qr_pe_param against an integer CORDIC reference model
module tb_qr_pe_param;
  localparam int DW = 12;
  localparam int N = 6;
  logic i_clk = 1'b0;
  logic i_rst, i_valid, i_mode, i_ready;
  logic signed [DW-1:0] i_real_x, i_imag_x, i_real_y, i_imag_y;
  logic o_ready, o_valid, o_mode, o_busy;
  logic signed [DW-1:0] o_real_x, o_imag_x, o_real_y, o_imag_y;
  always #5 i_clk = ~i_clk;
  qr_pe_param #(.DATA_W(DW), .GUARD_W(2), .NUM_ITER(N)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_mode(i_mode),
    .i_real_x(i_real_x), .i_imag_x(i_imag_x), .i_real_y(i_real_y), .i_imag_y(i_imag_y),
    .o_valid(o_valid), .i_ready(i_ready), .o_mode(o_mode),
    .o_real_x(o_real_x), .o_imag_x(o_imag_x), .o_real_y(o_real_y), .o_imag_y(o_imag_y),
    .o_busy(o_busy)
  );
  typedef struct {
    bit m;
    int rx, ix, ry, iy;
    bit has_ref;
    int refv;
  } exp_t;
  exp_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int da[N], db[N], dc[N];
  bit fa, fb;
  function automatic int clamp(int v, int lo, int hi);
    return v < lo ? lo : (v > hi ? hi : v);
  endfunction
  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      da[i] = 1;
      db[i] = 1;
      dc[i] = 1;
    end
    fa = 0;
    fb = 0;
  endfunction
  // N micro-rotations on (x,y); d in {+1,-1}; sel picks which direction set is recorded or replayed
  function automatic void pass(inout int x, inout int y, input bit v, input int sel);
    for (int i = 0; i < N; i++) begin
      int d, xs, ys;
      d = v ? (y >= 0 ? -1 : 1) : (sel == 0 ? da[i] : (sel == 1 ? db[i] : dc[i]));
      if (v) begin
        if (sel == 0) da[i] = d;
        else if (sel == 1) db[i] = d;
        else dc[i] = d;
      end
      xs = x >>> i;
      ys = y >>> i;
      x = clamp(x - d * ys, -8192, 8191);
      y = clamp(y + d * xs, -8192, 8191);
    end
  endfunction
  function automatic exp_t model(bit m, int xr, int xi, int yr, int yi);
    exp_t e;
    int ax, ay, bx, by, p, q, r, s;
    if (m) begin
      fa = xr < 0;
      fb = yr < 0;
    end
    ax = fa ? -xr : xr;
    ay = fa ? -xi : xi;
    bx = fb ? -yr : yr;
    by = fb ? -yi : yi;
    pass(ax, ay, m, 0);
    pass(bx, by, m, 1);
    p = ax;
    q = bx;
    r = ay;
    s = by;
    pass(p, q, m, 2);
    if (!m) pass(r, s, 0, 2);
    e.m = m;
    e.rx = clamp(p, -2048, 2047);
    e.ry = clamp(q, -2048, 2047);
    e.ix = m ? 0 : clamp(r, -2048, 2047);
    e.iy = m ? 0 : clamp(s, -2048, 2047);
    e.has_ref = 0;
    e.refv = 0;
    return e;
  endfunction
  task automatic chk(input string name, input int got, input int req);
    n_cmp++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask
  task automatic send(input bit m, input int xr, input int xi, input int yr, input int yi,
                      input bit has_ref, input int refv);
    exp_t e;
    int k;
    k = 0;
    while (!o_ready && k < 200) begin
      @(posedge i_clk);
      #1;
      k++;
    end
    if (!o_ready) begin
      chk("send_wait_ready", int'(o_ready), 1);
      return;
    end
    i_valid = 1;
    i_mode = m;
    i_real_x = DW'(xr);
    i_imag_x = DW'(xi);
    i_real_y = DW'(yr);
    i_imag_y = DW'(yi);
    e = model(m, xr, xi, yr, yi);
    e.has_ref = has_ref;
    e.refv = refv;
    @(posedge i_clk);
    sbq.push_back(e);
    #1;
    i_valid = 0;
  endtask
  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"}, int'(o_ready), 1);
    chk({tag, "_valid_busy_mode"}, int'({o_valid, o_busy, o_mode}), 0);
    chk({tag, "_rx"}, int'(o_real_x), 0);
    chk({tag, "_ix"}, int'(o_imag_x), 0);
    chk({tag, "_ry"}, int'(o_real_y), 0);
    chk({tag, "_iy"}, int'(o_imag_y), 0);
  endtask
  initial begin
    exp_t e;
    int diff;
    forever begin
      @(negedge i_clk);
      if (!i_rst && o_valid && i_ready) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_output: got rx=%0d with no transaction outstanding, required none", o_real_x);
        end else begin
          e = sbq.pop_front();
          if (int'(o_mode) != int'(e.m) || int'(o_real_x) != e.rx || int'(o_imag_x) != e.ix ||
              int'(o_real_y) != e.ry || int'(o_imag_y) != e.iy) begin
            n_bad++;
            $display("FAIL result: got mode=%0d rx=%0d ix=%0d ry=%0d iy=%0d required mode=%0d rx=%0d ix=%0d ry=%0d iy=%0d",
                     o_mode, o_real_x, o_imag_x, o_real_y, o_imag_y, e.m, e.rx, e.ix, e.ry, e.iy);
          end
          if (e.has_ref) begin
            n_cmp++;
            diff = int'(o_real_x) - e.refv;
            if (diff > 4 || diff < -4) begin
              n_bad++;
              $display("FAIL magnitude: got %0d required %0d +-4", o_real_x, e.refv);
            end
          end
        end
      end
    end
  end
  initial begin
    int k;
    logic [4*DW-1:0] snap;
    i_rst = 1;
    i_valid = 0;
    i_mode = 0;
    i_ready = 1;
    i_real_x = '0;
    i_imag_x = '0;
    i_real_y = '0;
    i_imag_y = '0;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_state("reset");
    i_rst = 0;
    // basic vectoring, with latency and busy checks
    send(1, 256, 0, 0, 0, 1, 694);
    chk("busy_after_accept", int'({o_busy, o_ready}), 2);
    k = 0;
    while (!o_valid && k < 30) begin
      @(posedge i_clk);
      #1;
      k++;
    end
    chk("latency", k, 13);
    send(1, 256, 0, 256, 0, 1, 982);
    send(0, 256, 0, 256, 0, 1, 982);
    send(1, -256, 0, 0, 0, 1, 694);
    send(1, 2047, 2047, 2047, 2047, 1, 2047);
    // backpressure: results must hold and new offers must be ignored
    send(1, 300, -100, 50, 200, 0, 0);
    i_ready = 0;
    k = 0;
    while (!o_valid && k < 40) begin
      @(posedge i_clk);
      #1;
      k++;
    end
    chk("stall_reach_valid", int'(o_valid), 1);
    snap = {o_real_x, o_imag_x, o_real_y, o_imag_y};
    for (int i = 0; i < 5; i++) begin
      i_valid = 1;
      i_mode = 0;
      i_real_x = DW'($urandom_range(0, 1000));
      @(posedge i_clk);
      #1;
      chk("stall_valid_ready", int'({o_valid, o_ready}), 2);
      n_cmp++;
      if (snap !== {o_real_x, o_imag_x, o_real_y, o_imag_y}) begin
        n_bad++;
        $display("FAIL stall_hold: got %h required %h", {o_real_x, o_imag_x, o_real_y, o_imag_y}, snap);
      end
    end
    i_valid = 0;
    i_ready = 1;
    @(posedge i_clk);
    #1;
    chk("stall_release", int'({o_valid, o_ready}), 1);
    // reset in PH2 aborts the transaction and clears stored directions
    send(1, 256, 0, 0, 0, 0, 0);
    repeat (8) @(posedge i_clk);
    #1;
    chk("pre_reset_busy", int'(o_busy), 1);
    i_rst = 1;
    @(posedge i_clk);
    #1;
    i_rst = 0;
    sbq.delete();
    model_reset();
    check_reset_state("abort");
    repeat (20) @(posedge i_clk);
    #1;
    chk("abort_no_output", int'(o_valid), 0);
    send(0, 256, 0, 0, 0, 0, 0);
    send(1, 256, 0, 0, 0, 1, 694);
    // randomized mix with random downstream backpressure
    for (int t = 0; t < 40; t++) begin
      send($urandom_range(0, 2) != 0,
           int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000,
           int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000, 0, 0);
      k = 0;
      while (!o_ready && k < 100) begin
        i_ready = $urandom_range(0, 2) != 0;
        @(posedge i_clk);
        #1;
        k++;
      end
      i_ready = 1;
      if (!o_ready) chk("random_return_idle", int'(o_ready), 1);
    end
    k = 0;
    while (sbq.size() != 0 && k < 100) begin
      @(posedge i_clk);
      #1;
      k++;
    end
    chk("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
